// File: rtl/uart_pkg.sv
// Shared types for the UART bus master.
// FSM encoding, grant encoding and default width.
package uart_pkg;

  localparam int DATA_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_RX = 1'b0,
    GNT_TX = 1'b1
  } grant_t;

endpackage

// File: rtl/uart_rx_hold.sv
// One-entry holding register for bytes read from the peripheral.
// Captures at the end of RD, presents valid/ready to the consumer.
module uart_rx_hold
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cap,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic [DATA_SIZE-1:0] o_data,
  output logic                 o_valid
);

  logic [DATA_SIZE-1:0] r_data;
  logic                 r_valid;

  // Capture on RD; data is held until the next capture so it stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_cap) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/uart_bus_master.sv
// Bridges TX/RX byte streams onto a parallel UART peripheral bus.
// Round-robin between writes and reads; one transfer per 3 cycles max.
module uart_bus_master
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 uart_cs,
  output logic                 uart_we,
  output logic                 uart_oe,
  inout  wire  [DATA_SIZE-1:0] uart_data,
  input  logic                 uart_tx_full,
  input  logic                 uart_rx_empty
);

  state_t               r_state;
  grant_t               r_last;
  logic [DATA_SIZE-1:0] r_tx_byte;
  logic                 r_cs;
  logic                 r_we;
  logic                 r_oe;

  logic                 w_idle;
  logic                 w_hold_full;
  logic                 w_tx_elig;
  logic                 w_rx_elig;
  logic                 w_tx_gnt;
  logic                 w_rx_gnt;
  logic                 w_cap;

  // A same-cycle rx handshake does not free the holding slot until next cycle.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_tx_elig = tx_valid && !uart_tx_full;
  assign w_rx_elig = !uart_rx_empty && !w_hold_full;
  assign w_tx_gnt  = w_idle && w_tx_elig &&
                     (!w_rx_elig || (r_last == GNT_RX));
  assign w_rx_gnt  = w_idle && w_rx_elig && !w_tx_gnt;
  assign w_cap     = (r_state == ST_RD);

  assign tx_ready  = w_tx_gnt;
  assign uart_cs   = r_cs;
  assign uart_we   = r_we;
  assign uart_oe   = r_oe;

  // Only the write strobe enables our bus driver, so it never fights oe.
  assign uart_data = r_we ? r_tx_byte : {DATA_SIZE{1'bz}};

  // Bus sequencer: IDLE -> WR/RD -> GAP -> IDLE, strobes registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= GNT_RX;
      r_tx_byte <= '0;
      r_cs      <= 1'b0;
      r_we      <= 1'b0;
      r_oe      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_tx_gnt) begin
            r_state   <= ST_WR;
            r_last    <= GNT_TX;
            r_tx_byte <= tx_data;
            r_cs      <= 1'b1;
            r_we      <= 1'b1;
          end else if (w_rx_gnt) begin
            r_state <= ST_RD;
            r_last  <= GNT_RX;
            r_cs    <= 1'b1;
            r_oe    <= 1'b1;
          end
        end
        ST_WR, ST_RD: begin
          r_state <= ST_GAP;
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_oe    <= 1'b0;
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_rx_hold #(
    .DATA_SIZE(DATA_SIZE)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_cap   (w_cap),
    .i_data  (uart_data),
    .i_ready (rx_ready),
    .o_data  (rx_data),
    .o_valid (w_hold_full)
  );

  assign rx_valid = w_hold_full;

endmodule
